sevenseg_scan: RTL and testbench

- Display back end for the stopwatch: consumes the four BCD digits from the minute/second counter and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Layout is MM.SS.
- Scans digits with an internal refresh prescaler and latches a coherent digit snapshot once per frame.
- In adjust mode, blinks the selected field (minutes or seconds).

---
 rtl/sevenseg_scan.sv | 116 +++++++++++
 tb/tb_sevenseg_scan.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Multiplexed 4-digit common-anode 7-segment driver (MM.SS) with a per-frame
// digit snapshot and field blinking in adjust mode.
module sevenseg_scan #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       RESET,
   input  logic       ADJ,
   input  logic       SEL,
   input  logic [3:0] dig3,
   input  logic [3:0] dig2,
   input  logic [3:0] dig1,
   input  logic [3:0] dig0,
   output logic [3:0] an,
   output logic [7:0] seg
);

   localparam int unsigned RW = $clog2(REFRESH_DIV);
   localparam int unsigned BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [RW-1:0]     ref_cnt_q,   ref_cnt_d;
   logic [1:0]        scan_idx_q,  scan_idx_d;
   logic [3:0][3:0]   snapshot_q,  snapshot_d;
   logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
   logic              blink_ph_q,  blink_ph_d;
   logic [3:0]        an_q,        an_d;
   logic [7:0]        seg_q,       seg_d;
   logic              tick;
   logic              blank;

   function automatic logic [7:0] decode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   always_comb begin
      ref_cnt_d   = ref_cnt_q + RW'(1);
      scan_idx_d  = scan_idx_q;
      snapshot_d  = snapshot_q;
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
      tick        = (ref_cnt_q == REF_LAST);

      if (tick) begin
         ref_cnt_d  = '0;
         scan_idx_d = scan_idx_q + 2'd1;
         // The snapshot is taken only at the frame boundary so all four digits stay coherent.
         if (scan_idx_q == 2'd3) begin
            snapshot_d = {dig3, dig2, dig1, dig0};
         end
      end

      if (ADJ) begin
         blink_ph_d = blink_ph_q;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end

      // scan_idx[1] set means the minutes field; SEL=0 picks minutes.
      blank = ADJ & blink_ph_q & (scan_idx_q[1] ^ SEL);

      an_d  = ~(4'b0001 << scan_idx_q);
      seg_d = decode(snapshot_q[scan_idx_q]);
      if (scan_idx_q == 2'd2) begin
         seg_d[7] = 1'b0;
      end
      if (blank) begin
         an_d  = '1;
         seg_d = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         ref_cnt_q   <= '0;
         scan_idx_q  <= '0;
         snapshot_q  <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         an_q        <= '1;
         seg_q       <= '1;
      end else begin
         ref_cnt_q   <= ref_cnt_d;
         scan_idx_q  <= scan_idx_d;
         snapshot_q  <= snapshot_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with REFRESH_DIV=4, BLINK_DIV=8; every
// output-register edge is compared against hand-derived an/seg values.
module tb_sevenseg_scan;

   logic       clk;
   logic       RESET;
   logic       ADJ;
   logic       SEL;
   logic [3:0] dig3, dig2, dig1, dig0;
   logic [3:0] an;
   logic [7:0] seg;

   int unsigned n_checks;
   int unsigned n_bad;

   sevenseg_scan #(
      .REFRESH_DIV (4),
      .BLINK_DIV   (8)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .ADJ   (ADJ),
      .SEL   (SEL),
      .dig3  (dig3),
      .dig2  (dig2),
      .dig1  (dig1),
      .dig0  (dig0),
      .an    (an),
      .seg   (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Checks n consecutive output-register edges against one an/seg pair.
   task automatic slot(input int n, input logic [3:0] exp_an, input logic [7:0] exp_seg,
                       input string tag);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_val({tag, ".an"},  {28'd0, an},  {28'd0, exp_an});
         check_val({tag, ".seg"}, {24'd0, seg}, {24'd0, exp_seg});
      end
   endtask

   initial begin
      n_checks = 0;
      n_bad    = 0;
      RESET = 1'b1; ADJ = 1'b0; SEL = 1'b0;
      dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd0; dig0 = 4'd0;

      slot(3, 4'b1111, 8'hFF, "reset");
      RESET = 1'b0;
      dig3 = 4'd5; dig2 = 4'd9; dig1 = 4'd3; dig0 = 4'd7;

      // first frame still shows the zero snapshot
      slot(4, 4'b1110, 8'hC0, "f0p0");
      slot(4, 4'b1101, 8'hC0, "f0p1");
      slot(4, 4'b1011, 8'h40, "f0p2");
      slot(4, 4'b0111, 8'hC0, "f0p3");

      // snapshot 5,9,3,7; change inputs mid-frame
      slot(4, 4'b1110, 8'hF8, "f1p0");
      slot(4, 4'b1101, 8'hB0, "f1p1");
      dig0 = 4'd8; dig3 = 4'd2;
      slot(4, 4'b1011, 8'h10, "f1p2");
      slot(4, 4'b0111, 8'h92, "f1p3_coherent");

      slot(4, 4'b1110, 8'h80, "f2p0_newdig");
      dig0 = 4'hC;
      slot(4, 4'b1101, 8'hB0, "f2p1");
      slot(4, 4'b1011, 8'h10, "f2p2");
      slot(4, 4'b0111, 8'hA4, "f2p3_newdig");

      slot(4, 4'b1110, 8'hFF, "f3p0_badbcd");
      dig0 = 4'd8;
      slot(4, 4'b1101, 8'hB0, "f3p1");
      ADJ = 1'b1; SEL = 1'b1;
      slot(4, 4'b1011, 8'h10, "f3p2_vis");
      slot(4, 4'b0111, 8'hA4, "f3p3_vis");

      slot(4, 4'b1111, 8'hFF, "f4p0_blank_sec");
      SEL = 1'b0;
      slot(4, 4'b1101, 8'hB0, "f4p1_unsel");
      slot(4, 4'b1011, 8'h10, "f4p2_vis");
      slot(4, 4'b0111, 8'hA4, "f4p3_vis");
      SEL = 1'b1;

      slot(4, 4'b1111, 8'hFF, "f5p0_blank_sec");
      slot(2, 4'b1111, 8'hFF, "f5p1_blank_sec");
      ADJ = 1'b0;
      slot(2, 4'b1101, 8'hB0, "f5p1_adj_off");
      slot(4, 4'b1011, 8'h10, "f5p2");
      slot(4, 4'b0111, 8'hA4, "f5p3");
      ADJ = 1'b1; SEL = 1'b0;

      slot(4, 4'b1110, 8'h80, "f6p0_vis");
      slot(4, 4'b1101, 8'hB0, "f6p1_vis");
      slot(2, 4'b1111, 8'hFF, "f6p2_blank_min");
      RESET = 1'b1;
      slot(2, 4'b1111, 8'hFF, "midreset");
      RESET = 1'b0;

      // restart: zero snapshot, blink visible half first
      slot(4, 4'b1110, 8'hC0, "r0p0");
      slot(4, 4'b1101, 8'hC0, "r0p1");
      slot(4, 4'b1111, 8'hFF, "r0p2_blank_min");
      slot(4, 4'b1111, 8'hFF, "r0p3_blank_min");
      ADJ = 1'b0;

      slot(4, 4'b1110, 8'h80, "r1p0");
      slot(4, 4'b1101, 8'hB0, "r1p1");
      slot(4, 4'b1011, 8'h10, "r1p2");
      slot(4, 4'b0111, 8'hA4, "r1p3");

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
